// File: rtl/mem_wb_elastic_reg.sv
// mem_wb_elastic_reg: MEM/WB pipeline register as a DEPTH-entry elastic FIFO with flush and hazard lookup
module mem_wb_elastic_reg #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       RFWEM,
    input  logic                       MtoRFSelM,
    input  logic [DW-1:0]              ALUOutM,
    input  logic [DW-1:0]              DMRD,
    input  logic [AW-1:0]              rtdM,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       RFWEW,
    output logic                       MtoRFSelW,
    output logic [DW-1:0]              ALUOutW,
    output logic [DW-1:0]              DMOutW,
    output logic [AW-1:0]              rtdW,
    output logic [DW-1:0]              wdW,
    output logic [$clog2(DEPTH):0]     count,
    input  logic [AW-1:0]              q_addr,
    output logic                       pend_hit
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rfwe_q [DEPTH];
    logic          sel_q  [DEPTH];
    logic [DW-1:0] alu_q  [DEPTH];
    logic [DW-1:0] dm_q   [DEPTH];
    logic [AW-1:0] rtd_q  [DEPTH];
    logic [DEPTH-1:0] hit;
    logic          push, pop;

    assign in_ready  = cnt_q != CW'(DEPTH);
    assign out_valid = cnt_q != '0;
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;
    assign count     = cnt_q;

    // Next pointers and occupancy; flush wins over any push or pop
    always_comb begin
        cnt_d = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
        wr_d  = flush ? '0 : wr_q + PW'(push);
        rd_d  = flush ? '0 : rd_q + PW'(pop);
    end

    // Pointer and occupancy registers, cleared immediately on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
        end
    end

    // Payload storage needs no reset: every output is gated by occupancy
    always_ff @(posedge clk) begin
        if (push) begin
            rfwe_q[wr_q] <= RFWEM;
            sel_q[wr_q]  <= MtoRFSelM;
            alu_q[wr_q]  <= ALUOutM;
            dm_q[wr_q]   <= DMRD;
            rtd_q[wr_q]  <= rtdM;
        end
    end

    // An entry is occupied when its distance from the head is below the count
    for (genvar g = 0; g < DEPTH; g++) begin : g_hit
        assign hit[g] = ({1'b0, PW'(g) - rd_q} < cnt_q) & rfwe_q[g] & (rtd_q[g] == q_addr);
    end

    // Head entry presented on the W side, forced to zero when empty
    always_comb begin
        RFWEW     = out_valid ? rfwe_q[rd_q] : 1'b0;
        MtoRFSelW = out_valid ? sel_q[rd_q]  : 1'b0;
        ALUOutW   = out_valid ? alu_q[rd_q]  : '0;
        DMOutW    = out_valid ? dm_q[rd_q]   : '0;
        rtdW      = out_valid ? rtd_q[rd_q]  : '0;
        wdW       = MtoRFSelW ? DMOutW : ALUOutW;
        pend_hit  = (|hit) & (q_addr != '0);
    end
endmodule

// File: tb/tb_mem_wb_elastic_reg.sv
// tb_mem_wb_elastic_reg: directed tests for the MEM/WB elastic register
module tb_mem_wb_elastic_reg;
    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic        RFWEM = 1'b0, MtoRFSelM = 1'b0, RFWEW, MtoRFSelW, pend_hit;
    logic [31:0] ALUOutM = '0, DMRD = '0, ALUOutW, DMOutW, wdW;
    logic [4:0]  rtdM = '0, rtdW, q_addr = '0;
    logic [1:0]  count;
    int tests = 0, fails = 0;

    mem_wb_elastic_reg #(.DW(32), .AW(5), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .RFWEM(RFWEM), .MtoRFSelM(MtoRFSelM), .ALUOutM(ALUOutM), .DMRD(DMRD), .rtdM(rtdM),
        .out_valid(out_valid), .out_ready(out_ready), .RFWEW(RFWEW), .MtoRFSelW(MtoRFSelW),
        .ALUOutW(ALUOutW), .DMOutW(DMOutW), .rtdW(rtdW), .wdW(wdW), .count(count),
        .q_addr(q_addr), .pend_hit(pend_hit)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic sel,
                         input logic [31:0] alu, input logic [31:0] dm, input logic [4:0] rd);
        in_valid = v; RFWEM = we; MtoRFSelM = sel; ALUOutM = alu; DMRD = dm; rtdM = rd;
    endtask

    task automatic test_reset();
        #2;
        tests++; if (count !== 2'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL reset_ctl got cnt=%0d ir=%b ov=%b exp 0 1 0", count, in_ready, out_valid); end
        tests++; if ({RFWEW, MtoRFSelW, ALUOutW, DMOutW, rtdW, wdW, pend_hit} !== '0) begin fails++; $display("FAIL reset_w got rtd=%h wd=%h ph=%b exp 0", rtdW, wdW, pend_hit); end
        #10 rst_n = 1'b1;
        step();
        step();
        tests++; if (count !== 2'd0 || in_ready !== 1'b1 || out_valid !== 1'b0 || wdW !== 32'h0 || pend_hit !== 1'b0) begin fails++; $display("FAIL idle got cnt=%0d ir=%b ov=%b wd=%h exp 0 1 0 0", count, in_ready, out_valid, wdW); end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        drive(1, 1, 0, 32'hAA, 32'h55, 5);
        step();
        drive(0, 0, 0, 0, 0, 0);
        tests++; if (out_valid !== 1'b1 || wdW !== 32'hAA || rtdW !== 5'd5 || RFWEW !== 1'b1 || DMOutW !== 32'h55) begin fails++; $display("FAIL single_out got ov=%b wd=%h rtd=%0d we=%b exp 1 aa 5 1", out_valid, wdW, rtdW, RFWEW); end
        step();
        tests++; if (out_valid !== 1'b0 || count !== 2'd0 || wdW !== 32'h0) begin fails++; $display("FAIL single_drain got ov=%b cnt=%0d wd=%h exp 0 0 0", out_valid, count, wdW); end
        out_ready = 1'b0;
    endtask

    task automatic test_full_order();
        drive(1, 1, 1, 32'h99, 32'h11, 3);
        step();
        drive(1, 1, 0, 32'h22, 32'h0, 4);
        step();
        tests++; if (count !== 2'd2 || in_ready !== 1'b0) begin fails++; $display("FAIL full got cnt=%0d ir=%b exp 2 0", count, in_ready); end
        drive(1, 1, 0, 32'h33, 32'h0, 6);
        step();
        drive(0, 0, 0, 0, 0, 0);
        tests++; if (count !== 2'd2 || wdW !== 32'h11 || rtdW !== 5'd3) begin fails++; $display("FAIL full_hold got cnt=%0d wd=%h rtd=%0d exp 2 11 3", count, wdW, rtdW); end
        out_ready = 1'b1;
        step();
        tests++; if (count !== 2'd1 || wdW !== 32'h22 || rtdW !== 5'd4 || MtoRFSelW !== 1'b0) begin fails++; $display("FAIL order_b got cnt=%0d wd=%h rtd=%0d exp 1 22 4", count, wdW, rtdW); end
        step();
        tests++; if (count !== 2'd0 || out_valid !== 1'b0 || wdW !== 32'h0) begin fails++; $display("FAIL order_end got cnt=%0d ov=%b wd=%h exp 0 0 0 (C must not appear)", count, out_valid, wdW); end
        out_ready = 1'b0;
    endtask

    task automatic test_push_pop();
        drive(1, 0, 0, 32'h100, 0, 1);
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 0, 32'h200 + i, 0, 2);
            #1;
            tests++; if (wdW !== (i == 0 ? 32'h100 : 32'h200 + i - 1)) begin fails++; $display("FAIL pp_head%0d got %h exp %h", i, wdW, (i == 0 ? 32'h100 : 32'h200 + i - 1)); end
            step();
            tests++; if (count !== 2'd1) begin fails++; $display("FAIL pp_cnt%0d got %0d exp 1", i, count); end
        end
        drive(0, 0, 0, 0, 0, 0);
        tests++; if (wdW !== 32'h209) begin fails++; $display("FAIL pp_last got %h exp 209", wdW); end
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        drive(1, 1, 0, 32'h51, 0, 1);
        step();
        drive(1, 1, 0, 32'h52, 0, 2);
        step();
        drive(1, 1, 0, 32'h53, 0, 3);
        flush = 1'b1; out_ready = 1'b1;
        step();
        flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        tests++; if (count !== 2'd0 || out_valid !== 1'b0 || wdW !== 32'h0) begin fails++; $display("FAIL flush got cnt=%0d ov=%b wd=%h exp 0 0 0", count, out_valid, wdW); end
        step();
        tests++; if (out_valid !== 1'b0 || wdW !== 32'h0) begin fails++; $display("FAIL flush_drop got ov=%b wd=%h exp 0 0", out_valid, wdW); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        tests++; if (count !== 2'd0 || in_ready !== 1'b1) begin fails++; $display("FAIL flush_empty got cnt=%0d ir=%b exp 0 1", count, in_ready); end
        out_ready = 1'b0;
        drive(1, 1, 0, 32'h54, 0, 4);
        step();
        drive(0, 0, 0, 0, 0, 0);
        tests++; if (wdW !== 32'h54 || count !== 2'd1) begin fails++; $display("FAIL post_flush got wd=%h cnt=%0d exp 54 1", wdW, count); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_hazard_reset();
        drive(1, 1, 0, 32'h70, 0, 7);
        step();
        drive(1, 1, 0, 32'h71, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        q_addr = 5'd7; #1;
        tests++; if (pend_hit !== 1'b1) begin fails++; $display("FAIL hit7 got %b exp 1", pend_hit); end
        q_addr = 5'd0; #1;
        tests++; if (pend_hit !== 1'b0) begin fails++; $display("FAIL hit0 got %b exp 0", pend_hit); end
        q_addr = 5'd7; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        tests++; if (pend_hit !== 1'b0 || count !== 2'd1 || rtdW !== 5'd0 || wdW !== 32'h71) begin fails++; $display("FAIL hit_pop got ph=%b cnt=%0d rtd=%0d wd=%h exp 0 1 0 71", pend_hit, count, rtdW, wdW); end
        drive(1, 1, 1, 32'h0, 32'h90, 9);
        step();
        drive(0, 0, 0, 0, 0, 0);
        q_addr = 5'd9; #1;
        tests++; if (pend_hit !== 1'b1 || count !== 2'd2) begin fails++; $display("FAIL hit9 got ph=%b cnt=%0d exp 1 2", pend_hit, count); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || pend_hit !== 1'b0) begin fails++; $display("FAIL async_rst_ctl got cnt=%0d ov=%b ir=%b ph=%b exp 0 0 1 0", count, out_valid, in_ready, pend_hit); end
        tests++; if ({RFWEW, MtoRFSelW, ALUOutW, DMOutW, rtdW, wdW} !== '0) begin fails++; $display("FAIL async_rst_w got rtd=%h wd=%h exp 0", rtdW, wdW); end
        #2 rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_order();
        test_push_pop();
        test_flush();
        test_hazard_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
